// File: rtl/rps_round_ctrl_if.sv
// Signal bundle between the key debouncers / display logic and the
// rock-paper-scissors round sequencer.
interface rps_round_ctrl_if;
    logic       start_pulse;
    logic [2:0] p1_pulse;
    logic [2:0] p2_pulse;
    logic [1:0] state;
    logic [1:0] p1_choice;
    logic [1:0] p2_choice;
    logic       p1_locked;
    logic       p2_locked;
    logic [1:0] result;
    logic [2:0] p1_score;
    logic [2:0] p2_score;
    logic       match_over;

    modport master (
        output start_pulse, p1_pulse, p2_pulse,
        input  state, p1_choice, p2_choice, p1_locked, p2_locked,
               result, p1_score, p2_score, match_over
    );

    modport slave (
        input  start_pulse, p1_pulse, p2_pulse,
        output state, p1_choice, p2_choice, p1_locked, p2_locked,
               result, p1_score, p2_score, match_over
    );
endinterface

// File: rtl/rps_round_ctrl.sv
// Rock-paper-scissors round sequencer: locks first choices, judges the round,
// holds the result for a reveal time, keeps score and ends the match.
//
// state | meaning
// IDLE  | power-up, waiting for start_pulse
// PICK  | collecting one valid choice per player
// SHOW  | result held for REVEAL_CYC cycles
// DONE  | match won, result held until start_pulse
module rps_round_ctrl #(
    parameter logic [23:0] REVEAL_CYC = 24'd12_000_000,
    parameter int          WIN_SCORE  = 3
) (
    input  logic         clk,
    input  logic         rst,
    rps_round_ctrl_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PICK = 2'd1;
    localparam logic [1:0] S_SHOW = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0]  WIN      = 3'(WIN_SCORE);
    localparam logic [23:0] CNT_LAST = REVEAL_CYC - 24'd1;

    logic [1:0]  state_q;
    logic [1:0]  p1_choice_q, p2_choice_q;
    logic        p1_locked_q, p2_locked_q;
    logic [1:0]  result_q;
    logic [2:0]  p1_score_q, p2_score_q;
    logic [23:0] cnt_q;

    logic [1:0]  p1_dec, p2_dec, verdict;

    // Only a single set bit is a legal key press; anything else decodes to none.
    function automatic logic [1:0] decode(input logic [2:0] p);
        case (p)
            3'b001:  decode = 2'd1;
            3'b010:  decode = 2'd2;
            3'b100:  decode = 2'd3;
            default: decode = 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] judge(input logic [1:0] a, input logic [1:0] b);
        if (a == b)
            judge = 2'd3;
        else if ((a == 2'd1 && b == 2'd2) || (a == 2'd2 && b == 2'd3) ||
                 (a == 2'd3 && b == 2'd1))
            judge = 2'd1;
        else
            judge = 2'd2;
    endfunction

    assign p1_dec  = decode(bus.p1_pulse);
    assign p2_dec  = decode(bus.p2_pulse);
    assign verdict = judge(p1_choice_q, p2_choice_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            p1_choice_q <= 2'd0;
            p2_choice_q <= 2'd0;
            p1_locked_q <= 1'b0;
            p2_locked_q <= 1'b0;
            result_q    <= 2'd0;
            p1_score_q  <= 3'd0;
            p2_score_q  <= 3'd0;
            cnt_q       <= 24'd0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start_pulse) begin
                        state_q     <= S_PICK;
                        p1_choice_q <= 2'd0;
                        p2_choice_q <= 2'd0;
                        p1_locked_q <= 1'b0;
                        p2_locked_q <= 1'b0;
                        result_q    <= 2'd0;
                        p1_score_q  <= 3'd0;
                        p2_score_q  <= 3'd0;
                        cnt_q       <= 24'd0;
                    end
                end
                S_PICK: begin
                    if (p1_locked_q && p2_locked_q) begin
                        state_q  <= S_SHOW;
                        result_q <= verdict;
                        cnt_q    <= 24'd0;
                        if (verdict == 2'd1 && p1_score_q != 3'd7)
                            p1_score_q <= p1_score_q + 3'd1;
                        if (verdict == 2'd2 && p2_score_q != 3'd7)
                            p2_score_q <= p2_score_q + 3'd1;
                    end else begin
                        if (!p1_locked_q && p1_dec != 2'd0) begin
                            p1_choice_q <= p1_dec;
                            p1_locked_q <= 1'b1;
                        end
                        if (!p2_locked_q && p2_dec != 2'd0) begin
                            p2_choice_q <= p2_dec;
                            p2_locked_q <= 1'b1;
                        end
                    end
                end
                S_SHOW: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= 24'd0;
                        if (p1_score_q == WIN || p2_score_q == WIN) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q     <= S_PICK;
                            p1_choice_q <= 2'd0;
                            p2_choice_q <= 2'd0;
                            p1_locked_q <= 1'b0;
                            p2_locked_q <= 1'b0;
                            result_q    <= 2'd0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 24'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.state      = state_q;
    assign bus.p1_choice  = p1_choice_q;
    assign bus.p2_choice  = p2_choice_q;
    assign bus.p1_locked  = p1_locked_q;
    assign bus.p2_locked  = p2_locked_q;
    assign bus.result     = result_q;
    assign bus.p1_score   = p1_score_q;
    assign bus.p2_score   = p2_score_q;
    assign bus.match_over = (state_q == S_DONE);
endmodule

// File: tb/tb_rps_round_ctrl.sv
// Directed bench for rps_round_ctrl: stimulus queues expected output snapshots
// tagged with a cycle number; a negedge monitor pops and compares them.
module tb_rps_round_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    typedef struct {
        int          at;
        logic [16:0] vec;
        string       name;
    } exp_t;
    exp_t sb_q[$];

    rps_round_ctrl_if bus ();

    rps_round_ctrl #(.REVEAL_CYC(24'd4), .WIN_SCORE(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // {state, p1_choice, p2_choice, p1_locked, p2_locked, result, p1_score, p2_score, match_over}
    function automatic logic [16:0] ev(input logic [1:0] st, input logic [1:0] c1,
                                       input logic [1:0] c2, input logic l1, input logic l2,
                                       input logic [1:0] res, input logic [2:0] s1,
                                       input logic [2:0] s2, input logic mo);
        ev = {st, c1, c2, l1, l2, res, s1, s2, mo};
    endfunction

    function automatic logic [16:0] dut_vec();
        dut_vec = {bus.state, bus.p1_choice, bus.p2_choice, bus.p1_locked, bus.p2_locked,
                   bus.result, bus.p1_score, bus.p2_score, bus.match_over};
    endfunction

    task automatic expect_now(input logic [16:0] v, input string nm);
        exp_t e;
        e.at = cyc;
        e.vec = v;
        e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic st, input logic [2:0] a, input logic [2:0] b);
        bus.start_pulse = st;
        bus.p1_pulse = a;
        bus.p2_pulse = b;
        tick(1);
        bus.start_pulse = 1'b0;
        bus.p1_pulse = 3'b000;
        bus.p2_pulse = 3'b000;
    endtask

    always @(negedge clk) begin
        while (sb_q.size() != 0 && sb_q[0].at <= cyc) begin
            exp_t e;
            logic [16:0] got;
            e = sb_q.pop_front();
            got = dut_vec();
            n_cmp++;
            if (e.at != cyc || got !== e.vec) begin
                n_bad++;
                $display("FAIL %s: cycle %0d got %b want %b (due cycle %0d)",
                         e.name, cyc, got, e.vec, e.at);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, %0d expectations pending", sb_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start_pulse = 1'b0;
        bus.p1_pulse = 3'b000;
        bus.p2_pulse = 3'b000;
        rst = 1'b0;
        tick(3);
        expect_now(ev(0,0,0,0,0,0,0,0,0), "reset_hold");
        n_cmp++;
        if (dut_vec() !== ev(0,0,0,0,0,0,0,0,0)) begin
            n_bad++;
            $display("FAIL reset_hold_direct: got %b", dut_vec());
        end
        rst = 1'b1;
        tick(1);
        expect_now(ev(0,0,0,0,0,0,0,0,0), "after_release");
        drive(0, 3'b001, 3'b000);
        expect_now(ev(0,0,0,0,0,0,0,0,0), "idle_ignores_choice");

        // Round 1: p1 rock beats p2 scissors, with start pulses in PICK and SHOW.
        drive(1, 3'b000, 3'b000);
        expect_now(ev(1,0,0,0,0,0,0,0,0), "start_to_pick");
        drive(0, 3'b001, 3'b000);
        expect_now(ev(1,1,0,1,0,0,0,0,0), "p1_lock_rock");
        drive(1, 3'b000, 3'b000);
        expect_now(ev(1,1,0,1,0,0,0,0,0), "start_ignored_pick");
        tick(1);
        drive(0, 3'b000, 3'b010);
        expect_now(ev(1,1,2,1,1,0,0,0,0), "p2_lock_scissors");
        tick(1);
        expect_now(ev(2,1,2,1,1,1,1,0,0), "show_p1_wins");
        drive(1, 3'b100, 3'b100);
        expect_now(ev(2,1,2,1,1,1,1,0,0), "start_ignored_show");
        n_cmp++;
        if (dut.cnt_q !== 24'd1) begin
            n_bad++;
            $display("FAIL start_ignored_show_cnt: got %0d want 1", dut.cnt_q);
        end
        tick(2);
        expect_now(ev(2,1,2,1,1,1,1,0,0), "show_last_cycle");
        tick(1);
        expect_now(ev(1,0,0,0,0,0,1,0,0), "show_to_pick");

        // Round 2: invalid vector, first lock final, draw.
        drive(0, 3'b011, 3'b000);
        expect_now(ev(1,0,0,0,0,0,1,0,0), "invalid_ignored");
        drive(0, 3'b001, 3'b000);
        expect_now(ev(1,1,0,1,0,0,1,0,0), "p1_rock");
        drive(0, 3'b100, 3'b000);
        expect_now(ev(1,1,0,1,0,0,1,0,0), "p1_relock_ignored");
        drive(0, 3'b000, 3'b001);
        tick(1);
        expect_now(ev(2,1,1,1,1,3,1,0,0), "draw_rock");
        tick(4);
        expect_now(ev(1,0,0,0,0,0,1,0,0), "draw_to_pick");

        // Round 3: same-edge locks, paper vs paper.
        drive(0, 3'b100, 3'b100);
        expect_now(ev(1,3,3,1,1,0,1,0,0), "same_edge_locks");
        tick(1);
        expect_now(ev(2,3,3,1,1,3,1,0,0), "draw_paper");
        tick(4);

        // Three p2 wins: paper covers rock, match ends on the third.
        for (int i = 1; i <= 3; i++) begin
            drive(0, 3'b001, 3'b100);
            tick(1);
            expect_now(ev(2,1,3,1,1,2,1,3'(i),0), "show_p2_wins");
            tick(4);
            if (i < 3)
                expect_now(ev(1,0,0,0,0,0,1,3'(i),0), "next_round");
            else
                expect_now(ev(3,1,3,1,1,2,1,3,1), "match_done");
        end
        drive(0, 3'b010, 3'b001);
        expect_now(ev(3,1,3,1,1,2,1,3,1), "done_ignores_choice");
        tick(2);
        expect_now(ev(3,1,3,1,1,2,1,3,1), "done_holds");
        drive(1, 3'b001, 3'b000);
        expect_now(ev(1,0,0,0,0,0,0,0,0), "new_match");
        n_cmp++;
        if (bus.p1_score !== 3'd0 || bus.p2_score !== 3'd0) begin
            n_bad++;
            $display("FAIL new_match_scores: got %0d/%0d", bus.p1_score, bus.p2_score);
        end

        // Reset in SHOW with the reveal counter at 2.
        drive(0, 3'b001, 3'b010);
        tick(1);
        expect_now(ev(2,1,2,1,1,1,1,0,0), "show_before_reset");
        tick(2);
        n_cmp++;
        if (dut.cnt_q !== 24'd2) begin
            n_bad++;
            $display("FAIL show_cnt_before_reset: got %0d want 2", dut.cnt_q);
        end
        rst = 1'b0;
        #1;
        expect_now(ev(0,0,0,0,0,0,0,0,0), "async_reset_show");
        n_cmp++;
        if (dut_vec() !== ev(0,0,0,0,0,0,0,0,0)) begin
            n_bad++;
            $display("FAIL async_reset_show_direct: got %b", dut_vec());
        end
        tick(1);
        rst = 1'b1;
        tick(1);
        expect_now(ev(0,0,0,0,0,0,0,0,0), "idle_after_reset");
        tick(6);

        // Leftover expectations count as misses.
        while (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s: never compared, want %b", e.name, e.vec);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rps_round_ctrl.md
# rps_round_ctrl

Round sequencer for the rock-paper-scissors game. It consumes the one-cycle key pulses produced by the per-key debouncers for the start key and both players' three choice keys. It locks each player's first choice, judges the round, holds the result for a fixed reveal time, keeps score, and ends the match at a target score. Its outputs drive the display and LED logic directly.

## Interface
- REVEAL_CYC, 24'd12_000_000: reveal hold time in clk cycles (1 s at 12 MHz). Legal range 1..2^24-1.
- WIN_SCORE, 3: round wins needed to end the match. Legal range 1..7.
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, asynchronous, active-low.
- start_pulse  in  1  debounced start-key pulse, one cycle high.
- p1_pulse  in  3  player-1 debounced pulses: [0]=rock, [1]=scissors, [2]=paper.
- p2_pulse  in  3  player-2 debounced pulses, same bit map as p1_pulse.
- state  out  2  current state: 0=IDLE, 1=PICK, 2=SHOW, 3=DONE.
- p1_choice, p2_choice  out  2 each  0=none, 1=rock, 2=scissors, 3=paper.
- p1_locked, p2_locked  out  1 each  player has a choice captured this round.
- result  out  2  0=none, 1=p1 wins, 2=p2 wins, 3=draw.
- p1_score, p2_score  out  3 each  rounds won in the current match.
- match_over  out  1  high only in DONE.

## Operation
- Reset (rst low, async): state=IDLE; every other output is 0; reveal counter is 0.
- IDLE:
  - All choice-key pulses are ignored.
  - start_pulse → PICK. Scores, choices, locks, and result are cleared on the same edge.
- PICK:
  - A player's choice is captured on the first cycle their pulse vector has exactly one bit set while that player is unlocked. Capture sets pX_choice and pX_locked.
  - A pulse vector with 2 or 3 bits set is invalid and ignored.
  - Pulses from an already-locked player are ignored; the first lock is final.
  - Both players may lock on the same edge.
  - start_pulse is ignored.
  - Choices stay visible as soon as they are locked; masking is the display logic's job.
  - Once both players are locked → SHOW.
- Judging, registered on the PICK→SHOW edge:
  - Rock beats scissors, scissors beats paper, paper beats rock; equal choices are a draw.
  - The winner's score increments by 1. Scores saturate at 7, which is unreachable for legal WIN_SCORE.
- SHOW:
  - result is held. The 24-bit reveal counter starts at 0 on entry and increments every cycle.
  - All pulses, including start_pulse, are ignored.
  - On the edge where the counter equals REVEAL_CYC-1:
    - If p1_score or p2_score equals WIN_SCORE → DONE. Choices, locks, and result are held for display.
    - Otherwise → PICK. Choices, locks, and result are cleared to 0; the counter is cleared.
- DONE:
  - match_over=1; scores, choices, and result are held.
  - Choice pulses are ignored.
  - start_pulse → PICK with scores, choices, locks, and result cleared: a new match.
- The single rule for a new match: start_pulse is acted on only in IDLE and DONE.

## Timing
- All outputs are registered; no combinational input-to-output path.
- A pulse sampled at edge E: pX_choice and pX_locked are valid after E.
- The second lock at edge E: state=SHOW, result, and the score update after edge E+1. The counter is 0 in the first SHOW cycle.
- SHOW lasts exactly REVEAL_CYC cycles. The state after SHOW appears at edge E+1+REVEAL_CYC.
- start_pulse at edge E in IDLE or DONE gives state=PICK after E. A choice pulse in that same cycle is not captured.
- rst asserted mid-round (any state) returns all outputs to reset values immediately, with no completion of the round. Release resumes at IDLE.

## Test plan
- **Reset values:** hold rst low for 3 cycles, then release → state=0 and every output 0. Pulse p1_pulse=3'b001 with no start → still IDLE, p1_locked=0.
- **Single round, p1 win:** use REVEAL_CYC=4, WIN_SCORE=3.
  - Drive start, then p1_pulse=001 (rock), then 3 cycles later p2_pulse=010 (scissors).
  - Required: state=2 one cycle after p2 locks; result=1, p1_score=1.
  - Exactly 4 cycles later state=1, with choices, locks, and result at 0.
- **Same-edge locks, draw, ignored extra pulses:**
  - Drive p1_pulse=100 and p2_pulse=100 in one cycle → draw: result=3, scores unchanged.
  - Drive p1_pulse=011 (invalid) → not captured.
  - Drive p1 rock, then p1 paper before p2 picks → p1_choice stays 1.
- **Match end:** play p2 paper vs p1 rock three times.
  - Required: p2_score=3, then state=3, match_over=1, result=2 held.
  - A choice pulse in DONE changes nothing. start_pulse → state=1 with scores 0.
- **Reset mid-operation:** pull rst low during SHOW with the counter at 2 → all outputs 0 in the same cycle, state=IDLE after release.
- **Start ignored:** start_pulse during PICK and during SHOW leaves locks, scores, and the reveal counter unchanged.
